// File: rtl/alu_issue_if.sv
// Request/response handshake bundle for alu_issue.
// master is the requester/consumer side, slave is the issue block.
interface alu_issue_if #(
  parameter int WORD_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [5:0]           req_opcode;
  logic [5:0]           req_funct;
  logic [WORD_SIZE-1:0] req_a;
  logic [WORD_SIZE-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_result;
  logic                 rsp_zero;
  logic                 rsp_overflow;
  logic                 rsp_error;

  modport master (
    output req_valid, req_opcode, req_funct,
    output req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result,
    input  rsp_zero, rsp_overflow, rsp_error
  );

  modport slave (
    input  req_valid, req_opcode, req_funct,
    input  req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result,
    output rsp_zero, rsp_overflow, rsp_error
  );
endinterface

// File: rtl/alu_issue.sv
// MIPS ALU issue block: decodes one request, drives a registered ALU,
// captures its result and counts signed overflows (saturating).
module alu_issue #(
  parameter int WORD_SIZE           = 32,
  parameter int CONTROL_SIGNAL_SIZE = 4,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  alu_issue_if.slave                     bus,
  output logic [WORD_SIZE-1:0]           alu_a,
  output logic [WORD_SIZE-1:0]           alu_b,
  output logic [CONTROL_SIGNAL_SIZE-1:0] alu_control,
  input  logic [WORD_SIZE-1:0]           alu_result,
  input  logic                           alu_zero,
  input  logic                           alu_cout,
  input  logic                           alu_overflow,
  input  logic                           alu_invalid,
  output logic [COUNT_WIDTH-1:0]         ovf_count
);
  localparam int CW = CONTROL_SIGNAL_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          req_ready;
  logic          rsp_valid;
  logic          accept;
  logic          is_r;
  logic [5:0]    op;
  logic [5:0]    fn;
  logic [CW-1:0] dec_ctrl;
  logic          dec_err;
  logic          dec_ovf;
  logic          err_q;
  logic          ovf_en_q;
  logic          cap_ovf;
  logic          cap_err;

  logic [WORD_SIZE-1:0] rsp_result_q;
  logic                 rsp_zero_q;
  logic                 rsp_overflow_q;
  logic                 rsp_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = ISSUE;
      end
      ISSUE: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_ready & bus.req_valid;
  assign op     = bus.req_opcode;
  assign fn     = bus.req_funct;
  assign is_r   = (op == 6'h00);

  // dec_ovf marks the signed add/sub forms whose overflow is reported
  always_comb begin
    dec_ctrl = CW'(4'hF);
    dec_err  = 1'b1;
    dec_ovf  = 1'b0;
    unique case (1'b1)
      is_r && fn == 6'h20: begin
        dec_ctrl = CW'(4'h2); dec_err = 1'b0; dec_ovf = 1'b1;
      end
      is_r && fn == 6'h21: begin
        dec_ctrl = CW'(4'h3); dec_err = 1'b0;
      end
      is_r && fn == 6'h22: begin
        dec_ctrl = CW'(4'h6); dec_err = 1'b0; dec_ovf = 1'b1;
      end
      is_r && fn == 6'h23: begin
        dec_ctrl = CW'(4'h6); dec_err = 1'b0;
      end
      is_r && fn == 6'h24: begin
        dec_ctrl = CW'(4'h0); dec_err = 1'b0;
      end
      is_r && fn == 6'h25: begin
        dec_ctrl = CW'(4'h1); dec_err = 1'b0;
      end
      is_r && fn == 6'h27: begin
        dec_ctrl = CW'(4'hC); dec_err = 1'b0;
      end
      is_r && fn == 6'h2A: begin
        dec_ctrl = CW'(4'h7); dec_err = 1'b0;
      end
      op == 6'h08: begin
        dec_ctrl = CW'(4'h2); dec_err = 1'b0; dec_ovf = 1'b1;
      end
      op == 6'h09: begin
        dec_ctrl = CW'(4'h3); dec_err = 1'b0;
      end
      op == 6'h0A: begin
        dec_ctrl = CW'(4'h7); dec_err = 1'b0;
      end
      op == 6'h0C: begin
        dec_ctrl = CW'(4'h0); dec_err = 1'b0;
      end
      op == 6'h0D: begin
        dec_ctrl = CW'(4'h1); dec_err = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      err_q       <= 1'b0;
      ovf_en_q    <= 1'b0;
    end else if (accept) begin
      alu_a       <= bus.req_a;
      alu_b       <= bus.req_b;
      alu_control <= dec_ctrl;
      err_q       <= dec_err;
      ovf_en_q    <= dec_ovf;
    end
  end

  assign cap_err = err_q | alu_invalid;
  assign cap_ovf = ovf_en_q & alu_overflow & ~cap_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
      ovf_count      <= '0;
    end else if (state_q == ISSUE) begin
      rsp_result_q   <= alu_result;
      rsp_zero_q     <= alu_zero;
      rsp_overflow_q <= cap_ovf;
      rsp_error_q    <= cap_err;
      if (cap_ovf && ovf_count != '1)
        ovf_count <= ovf_count + 1'b1;
    end
  end

  logic unused_cout;
  assign unused_cout = alu_cout;

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_error    = rsp_error_q;
endmodule
